// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared state encoding and widths for the pulse stretcher
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int CNT_W  = 16;
  localparam int PEND_W = 8;

endpackage

// File: rtl/sat_updown_counter.sv
// rtl/sat_updown_counter.sv - saturating up/down request counter with drop strobe
module sat_updown_counter
  import pulse_stretcher_pkg::*;
#(
  parameter int MAX = 15,
  parameter int W   = PEND_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         ovf_strobe
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // A simultaneous inc and dec nets to zero, so only a lone inc at MAX is a drop.
  always_comb begin
    ovf_strobe = inc && !dec && (count == MAX_V);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({inc, dec})
        2'b10: if (count != MAX_V) count <= count + W'(1);
        2'b01: if (count != '0)    count <= count - W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - request-queued pulse stretcher with fixed high time and guaranteed low gap
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HIGH_CYCLES = 5000,
  parameter int LOW_CYCLES  = 5000,
  parameter int PEND_MAX    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              clr_ovf,
  output logic              pulse_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             q_inc, q_dec, drop;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    q_inc     = 1'b0;
    q_dec     = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (trig) state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        q_inc = trig;
        if (cnt == HIGH_LAST) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end
      end
      ST_GAP: begin
        q_inc = trig;
        if (cnt == LOW_LAST) begin
          cnt_nxt = '0;
          // Queued requests are served first; a fresh trig with an empty queue starts directly.
          if (pend_cnt != '0) begin
            state_nxt = ST_HIGH;
            q_dec     = 1'b1;
          end else if (trig) begin
            state_nxt = ST_HIGH;
            q_inc     = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pulse_out <= (state_nxt == ST_HIGH);
      busy      <= (state_nxt != ST_IDLE);
    end
  end

  sat_updown_counter #(
    .MAX (PEND_MAX),
    .W   (PEND_W)
  ) u_pend (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (q_inc),
    .dec        (q_dec),
    .count      (pend_cnt),
    .ovf_strobe (drop)
  );

  // A drop at the same edge as a clear must leave the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL have parameter HIGH_CYCLES, default 5000, meaning minimum and exact output high time in clk cycles (range 1..65535).
REQ-002 SHALL have parameter LOW_CYCLES, default 5000, meaning guaranteed output low gap between consecutive pulses in clk cycles (range 1..65535).
REQ-003 SHALL have parameter PEND_MAX, default 15, meaning pending-request queue depth (range 1..255).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port trig  input  1  request strobe; each cycle high counts as one request.
REQ-007 SHALL have port clr_ovf  input  1  clears the overflow flag.
REQ-008 SHALL have port pulse_out  output  1  registered stretched pulse that drives the actuator/LED.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-010 SHALL have port pend_cnt  output  8  number of queued requests not yet issued.
REQ-011 SHALL have port ovf  output  1  sticky flag: a request was dropped.

Function
REQ-012 SHALL implement FSM states IDLE, HIGH and GAP, with pulse_out=1 only in HIGH.
REQ-013 SHALL, in IDLE with trig=1 at edge n, enter HIGH so that pulse_out=1 from cycle n+1, giving latency 1 cycle.
REQ-014 SHALL hold HIGH for exactly HIGH_CYCLES cycles using a 16-bit counter cleared on state entry, then enter GAP.
REQ-015 SHALL hold GAP for exactly LOW_CYCLES cycles, then enter HIGH if a request is pending (trig at that edge counts), otherwise IDLE.
REQ-016 SHALL, when trig=1 in HIGH or GAP, add the request to pend_cnt; pend_cnt never exceeds PEND_MAX.
REQ-017 SHALL decrement pend_cnt by 1 on each GAP->HIGH transition served from the queue.
REQ-018 SHALL, when trig increments and the queue is served at the same edge, leave pend_cnt unchanged.
REQ-019 SHALL use trig directly to start a pulse when the FSM leaves GAP with pend_cnt=0 and trig=1, with no queue entry.
REQ-020 SHALL, on trig=1 with pend_cnt=PEND_MAX and no dequeue at that edge, drop the request, keep pend_cnt at PEND_MAX and set ovf=1 at the next edge.
REQ-021 SHALL keep ovf set until clr_ovf=1; if clr_ovf and a new drop occur at the same edge, the set wins.
REQ-022 SHALL drive busy=1 in HIGH and GAP, and 0 in IDLE.
REQ-023 SHALL register all outputs, with no combinational path from trig to pulse_out.
REQ-024 SHALL never produce a high run shorter or longer than HIGH_CYCLES, or a low run between pulses shorter than LOW_CYCLES.

Reset
REQ-025 SHALL, on rst_n=0 at a clk edge, force state IDLE, counter 0, pulse_out 0, busy 0, pend_cnt 0 and ovf 0.
REQ-026 SHALL, on reset mid-pulse, drop pulse_out at the next edge and discard all queued requests; the LOW_CYCLES gap is not enforced across reset.
REQ-027 SHALL ignore trig during the reset cycle; the first request is accepted at the first edge with rst_n=1.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/HIGH/GAP) and the 16-bit counter width constant in the shared project package.
REQ-029 SHALL implement the saturating up/down request counter as a sub-module named sat_updown_counter (inputs inc, dec, output count and overflow strobe).
REQ-030 SHALL keep a single always block per state register and no latches.

Verification (HIGH_CYCLES=4, LOW_CYCLES=3, PEND_MAX=2)
REQ-031 SHALL verify: single trig at cycle 10 -> pulse_out=1 for cycles 11-14, then busy=1 for cycles 15-17, then IDLE at 18 with pend_cnt=0.
REQ-032 SHALL verify: trig at cycles 10 and 12 -> pulses at 11-14 and 18-21, with exactly 3 low cycles (15-17) between them.
REQ-033 SHALL verify: trig held high for cycles 10-15 -> first pulse at 11-14, pend_cnt saturates at 2, ovf=1, and exactly 3 pulses are issued in total.
REQ-034 SHALL verify: trig at the last GAP cycle with pend_cnt=1 -> next pulse starts and pend_cnt stays 1.
REQ-035 SHALL verify: rst_n=0 at cycle 12 during a pulse -> pulse_out=0, pend_cnt=0 and ovf=0 at cycle 13; trig at cycle 14 -> pulse at 15-18.
REQ-036 SHALL verify: clr_ovf and an overflow drop at the same edge -> ovf remains 1.
